// File: rtl/id_ex_stage.sv
// Decode stage and ID/EX pipeline register for the 64-bit LEGv8 pipeline.
// Drives the register-file read addresses combinationally, captures operands and
// decoded control into the EX register, and inserts a one-cycle bubble on a
// load-use hazard against the load currently held in EX. A branch flush from EX
// kills the instruction in decode.
module id_ex_stage #(
  parameter int XLEN     = 64,
  parameter int ZERO_REG = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_d,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  output logic [4:0]      ra1,
  output logic [4:0]      ra2,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic            flush_e,
  output logic            stall_f,
  output logic            valid_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [XLEN-1:0] imm_e,
  output logic [4:0]      wa_e,
  output logic            reg_write_e,
  output logic            mem_read_e,
  output logic            mem_write_e,
  output logic            alu_src_e,
  output logic            branch_e,
  output logic [1:0]      alu_op_e
);

  localparam logic [4:0] ZR = 5'(ZERO_REG);

  logic [10:0]     op;
  logic            is_ldur, is_stur, is_cbz, is_r;
  logic            uses1, uses2, hz;
  logic            reg_write_d, mem_read_d, mem_write_d, alu_src_d, branch_d;
  logic [1:0]      alu_op_d;
  logic [XLEN-1:0] imm_d;

  logic            valid_q, reg_write_q, mem_read_q, mem_write_q, alu_src_q, branch_q;
  logic [1:0]      alu_op_q;
  logic [4:0]      wa_q;
  logic [XLEN-1:0] pc_q, rd1_q, rd2_q, imm_q;

  // Opcode decode, read-address selection and immediate extraction.
  always_comb begin
    op      = instr_d[31:21];
    is_ldur = (op == 11'b11111000010);
    is_stur = (op == 11'b11111000000);
    is_cbz  = (instr_d[31:24] == 8'b10110100);
    is_r    = (op == 11'b10001011000) || (op == 11'b11001011000) ||
              (op == 11'b10001010000) || (op == 11'b10101010000);

    uses1 = is_ldur | is_stur | is_r;
    uses2 = is_r | is_stur | is_cbz;

    ra1 = instr_d[9:5];
    ra2 = (is_stur | is_cbz) ? instr_d[4:0] : instr_d[20:16];

    reg_write_d = is_ldur | is_r;
    mem_read_d  = is_ldur;
    mem_write_d = is_stur;
    alu_src_d   = is_ldur | is_stur;
    branch_d    = is_cbz;
    alu_op_d    = is_r ? 2'b10 : (is_cbz ? 2'b01 : 2'b00);

    imm_d = '0;
    if (is_ldur | is_stur) imm_d = {{(XLEN-9){instr_d[20]}}, instr_d[20:12]};
    else if (is_cbz)       imm_d = {{(XLEN-21){instr_d[23]}}, instr_d[23:5], 2'b00};
  end

  // Load-use hazard against the load sitting in EX; XZR never carries a dependency.
  always_comb begin
    hz = valid_d & valid_q & mem_read_q & (wa_q != ZR) &
         ((uses1 & (wa_q == ra1)) | (uses2 & (wa_q == ra2)));
    stall_f = hz & ~flush_e & ~reset;
  end

  // EX register: flush and hazard both insert a zeroed bubble, otherwise capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0; reg_write_q <= 1'b0; mem_read_q <= 1'b0; mem_write_q <= 1'b0;
      alu_src_q <= 1'b0; branch_q <= 1'b0; alu_op_q <= '0; wa_q <= '0;
      pc_q <= '0; rd1_q <= '0; rd2_q <= '0; imm_q <= '0;
    end else if (flush_e || hz) begin
      valid_q <= 1'b0; reg_write_q <= 1'b0; mem_read_q <= 1'b0; mem_write_q <= 1'b0;
      alu_src_q <= 1'b0; branch_q <= 1'b0; alu_op_q <= '0; wa_q <= '0;
      pc_q <= '0; rd1_q <= '0; rd2_q <= '0; imm_q <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d & valid_d;
      mem_read_q  <= mem_read_d  & valid_d;
      mem_write_q <= mem_write_d & valid_d;
      alu_src_q   <= alu_src_d   & valid_d;
      branch_q    <= branch_d    & valid_d;
      alu_op_q    <= valid_d ? alu_op_d : 2'b00;
      wa_q        <= instr_d[4:0];
      pc_q        <= pc_d;
      rd1_q       <= rd1;
      rd2_q       <= rd2;
      imm_q       <= imm_d;
    end
  end

  assign valid_e     = valid_q;
  assign pc_e        = pc_q;
  assign rd1_e       = rd1_q;
  assign rd2_e       = rd2_q;
  assign imm_e       = imm_q;
  assign wa_e        = wa_q;
  assign reg_write_e = reg_write_q;
  assign mem_read_e  = mem_read_q;
  assign mem_write_e = mem_write_q;
  assign alu_src_e   = alu_src_q;
  assign branch_e    = branch_q;
  assign alu_op_e    = alu_op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model of
// the EX register contents and the load-use stall rule.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, valid_d, flush_e;
  logic [31:0] instr_d;
  logic [63:0] pc_d, rd1, rd2;
  logic [4:0]  ra1, ra2, wa_e;
  logic        stall_f, valid_e, reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e;
  logic [63:0] pc_e, rd1_e, rd2_e, imm_e;
  logic [1:0]  alu_op_e;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .flush_e(flush_e), .stall_f(stall_f),
    .valid_e(valid_e), .pc_e(pc_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .wa_e(wa_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
    .mem_write_e(mem_write_e), .alu_src_e(alu_src_e), .branch_e(branch_e),
    .alu_op_e(alu_op_e)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [63:0] pc, r1, r2, imm;
    logic [4:0]  wa;
    logic        rw, mr, mw, as, br;
    logic [1:0]  aop;
  } ex_t;

  ex_t  m;            // model of the EX register
  int   n_chk = 0, n_err = 0;
  logic obs_stall, last_stall;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // instruction builders
  function automatic logic [31:0] f_ldur(input int rt, input int rn, input int imm9);
    logic [8:0] i = 9'(imm9);
    return {11'b11111000010, i, 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] f_stur(input int rt, input int rn, input int imm9);
    logic [8:0] i = 9'(imm9);
    return {11'b11111000000, i, 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] f_cbz(input int rt, input int off);
    logic [18:0] i = 19'(off);
    return {8'b10110100, i, 5'(rt)};
  endfunction
  function automatic logic [31:0] f_r(input int k, input int rd, input int rn, input int rm);
    logic [10:0] opc [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    return {opc[k], 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction

  // Reference decode: classify, then derive fields from the instruction class.
  // kind: 0 other, 1 LDUR, 2 STUR, 3 CBZ, 4 R-type
  function automatic int kind_of(input logic [31:0] ins);
    case (ins[31:21])
      11'b11111000010: return 1;
      11'b11111000000: return 2;
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: return 4;
      default: return (ins[31:24] == 8'hB4) ? 3 : 0;
    endcase
  endfunction

  task automatic ref_decode(input logic [31:0] ins, output ex_t d, output int a1, output int a2,
                            output bit u1, output bit u2);
    int     k = kind_of(ins);
    longint off;
    d    = '0;
    a1   = int'(ins[9:5]);
    a2   = (k == 2 || k == 3) ? int'(ins[4:0]) : int'(ins[20:16]);
    u1   = (k == 1 || k == 2 || k == 4);
    u2   = (k == 2 || k == 3 || k == 4);
    d.wa = ins[4:0];
    case (k)
      1: begin d.rw = 1; d.mr = 1; d.as = 1; off = longint'($signed(ins[20:12])); d.imm = 64'(off); end
      2: begin d.mw = 1; d.as = 1; off = longint'($signed(ins[20:12])); d.imm = 64'(off); end
      3: begin d.br = 1; d.aop = 2'b01; off = longint'($signed(ins[23:5])) * 4; d.imm = 64'(off); end
      4: begin d.rw = 1; d.aop = 2'b10; end
      default: ;
    endcase
  endtask

  task automatic chk_ex(input string tag);
    chk({tag, ".valid_e"}, 64'(valid_e), 64'(m.v));
    chk({tag, ".pc_e"}, pc_e, m.pc);
    chk({tag, ".rd1_e"}, rd1_e, m.r1);
    chk({tag, ".rd2_e"}, rd2_e, m.r2);
    chk({tag, ".imm_e"}, imm_e, m.imm);
    chk({tag, ".wa_e"}, 64'(wa_e), 64'(m.wa));
    chk({tag, ".ctrl"}, 64'({reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, alu_op_e}),
        64'({m.rw, m.mr, m.mw, m.as, m.br, m.aop}));
  endtask

  // One clock: drive on negedge, check comb outputs, advance model on posedge, check EX.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [63:0] pc, input logic [63:0] r1, input logic [63:0] r2,
                      input logic fl);
    ex_t d; int a1, a2; bit u1, u2, hz;
    @(negedge clk);
    valid_d = v; instr_d = ins; pc_d = pc; rd1 = r1; rd2 = r2; flush_e = fl;
    #1;
    ref_decode(ins, d, a1, a2, u1, u2);
    hz = v && m.v && m.mr && m.wa != 5'd31 &&
         ((u1 && int'(m.wa) == a1) || (u2 && int'(m.wa) == a2));
    chk({tag, ".ra1"}, 64'(ra1), 64'(a1));
    chk({tag, ".ra2"}, 64'(ra2), 64'(a2));
    chk({tag, ".stall_f"}, 64'(stall_f), 64'(hz && !fl));
    obs_stall  = stall_f;
    last_stall = hz && !fl;
    @(posedge clk);
    if (fl || hz) m = '0;
    else begin
      m = v ? d : ex_t'('0);
      m.v = v; m.pc = pc; m.r1 = r1; m.r2 = r2; m.imm = d.imm; m.wa = ins[4:0];
    end
    #1;
    chk_ex(tag);
  endtask

  logic [31:0] ins_r;

  initial begin
    reset = 1'b1; valid_d = 0; instr_d = '0; pc_d = '0; rd1 = '0; rd2 = '0; flush_e = 0;
    m = '0; last_stall = 0; obs_stall = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_ex("reset");
    chk("reset.stall_f", 64'(stall_f), 64'(0));
    @(negedge clk); reset = 1'b0;

    // ADD X3,X1,X2 with operands 5 and 7
    step("add", 1, f_r(0, 3, 1, 2), 64'h100, 64'd5, 64'd7, 0);
    chk("add.rd1_e", rd1_e, 64'd5);
    chk("add.wa_e", 64'(wa_e), 64'd3);
    chk("add.alu_op_e", 64'(alu_op_e), 64'd2);

    // LDUR X4,[X1,#-8] then dependent ADD: one-cycle stall, bubble, then ADD
    step("ldur", 1, f_ldur(4, 1, -8), 64'h104, 64'h40, 0, 0);
    chk("ldur.imm_e", imm_e, 64'hFFFF_FFFF_FFFF_FFF8);
    step("lu_add", 1, f_r(0, 5, 4, 2), 64'h108, 1, 2, 0);
    chk("lu_add.stall", 64'(obs_stall), 64'd1);
    chk("lu_add.bubble", 64'(valid_e), 64'd0);
    step("lu_add2", 1, f_r(0, 5, 4, 2), 64'h108, 1, 2, 0);
    chk("lu_add2.nostall", 64'(obs_stall), 64'd0);
    chk("lu_add2.valid", 64'(valid_e), 64'd1);

    // LDUR to XZR never stalls
    step("ldur31", 1, f_ldur(31, 1, 0), 64'h10C, 0, 0, 0);
    step("xzr_add", 1, f_r(0, 5, 31, 31), 64'h110, 0, 0, 0);
    chk("xzr.nostall", 64'(obs_stall), 64'd0);

    // LDUR X4 then STUR X4,[X6]: dependency via Rt on ra2
    step("ldur4", 1, f_ldur(4, 1, 0), 64'h114, 0, 0, 0);
    step("stur", 1, f_stur(4, 6, 0), 64'h118, 0, 0, 0);
    chk("stur.stall", 64'(obs_stall), 64'd1);
    step("stur2", 1, f_stur(4, 6, 0), 64'h118, 0, 0, 0);
    // LDUR X4 then CBZ X7: no dependency
    step("ldur4b", 1, f_ldur(4, 1, 0), 64'h11C, 0, 0, 0);
    step("cbz7", 1, f_cbz(7, 2), 64'h120, 0, 0, 0);
    chk("cbz7.nostall", 64'(obs_stall), 64'd0);

    // Flush coincident with a load-use hazard
    step("ldur4c", 1, f_ldur(4, 1, 0), 64'h124, 0, 0, 0);
    step("flush", 1, f_r(1, 5, 4, 4), 64'h128, 0, 0, 1);
    chk("flush.stall", 64'(obs_stall), 64'd0);
    chk("flush.valid", 64'(valid_e), 64'd0);

    // CBZ X9,#-3 and an unrecognised opcode
    step("cbz9", 1, f_cbz(9, -3), 64'h12C, 0, 0, 0);
    chk("cbz9.imm_e", imm_e, 64'hFFFF_FFFF_FFFF_FFF4);
    chk("cbz9.branch_e", 64'(branch_e), 64'd1);
    step("nop", 1, 32'hD503_201F, 64'h130, 0, 0, 0);
    chk("nop.valid", 64'(valid_e), 64'd1);
    chk("nop.ctrl", 64'({reg_write_e, mem_read_e, mem_write_e, alu_src_e, branch_e, alu_op_e}), 64'd0);

    // Reset mid-stall
    step("ldur4d", 1, f_ldur(4, 1, 0), 64'h134, 9, 9, 0);
    @(negedge clk);
    valid_d = 1; instr_d = f_r(0, 5, 4, 2); flush_e = 0;
    #1 chk("prerst.stall", 64'(stall_f), 64'd1);
    reset = 1'b1; m = '0;
    #1;
    chk("rst.stall_f", 64'(stall_f), 64'd0);
    chk_ex("rst_async");
    @(posedge clk); #1;
    chk_ex("rst_hold");
    @(negedge clk); reset = 1'b0;

    // Randomized stream; an instruction is re-presented while stalled
    ins_r = '0; last_stall = 0;
    for (int i = 0; i < 400; i++) begin
      if (!last_stall) begin
        int k = $urandom_range(0, 9);
        int a = $urandom_range(0, 5), b = $urandom_range(0, 5), c = $urandom_range(0, 5);
        if ($urandom_range(0, 7) == 0) a = 31;
        case (k)
          0, 1, 2: ins_r = f_ldur(a, b, int'($urandom_range(0, 511)));
          3:       ins_r = f_stur(a, b, int'($urandom_range(0, 511)));
          4:       ins_r = f_cbz(a, int'($urandom_range(0, 524287)));
          5, 6, 7: ins_r = f_r(int'($urandom_range(0, 3)), a, b, c);
          default: ins_r = $urandom;
        endcase
      end
      step("rand", ($urandom_range(0, 7) != 0), ins_r, {$urandom, $urandom},
           {$urandom, $urandom}, {$urandom, $urandom}, ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
